// File: rtl/fxu_reservation_station_pkg.sv
// Shared out-of-order core types: widths, operand and entry records, and a
// small priority helper used to pick the lowest-index slot.
package ooo_pkg;

  localparam int DATA_W   = 16;
  localparam int TAG_W    = 4;
  localparam int OPC_W    = 4;
  localparam int ROB_SIZE = 16;

  // One source operand: either a resolved value (rdy=1) or the ROB tag
  // that will eventually produce it (rdy=0).
  typedef struct packed {
    logic              rdy;
    logic [DATA_W-1:0] value;
    logic [TAG_W-1:0]  owner;
  } operand_t;

  // Full reservation-station entry as seen by the scheduler.
  typedef struct packed {
    logic             valid;
    logic [OPC_W-1:0] opcode;
    logic [TAG_W-1:0] rt;
    operand_t         a;
    operand_t         b;
  } rs_entry_t;

  // Index of the lowest set bit of an up-to-8-entry vector (0 when empty;
  // callers qualify the result with an OR-reduction of the vector).
  function automatic logic [2:0] lowest_index(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/fxu_reservation_station_if.sv
// Dispatch, ROB broadcast and issue signals of one FXU reservation station.
// The slave modport is the station itself; master is the surrounding core.
interface fxu_reservation_station_if;
  import ooo_pkg::*;

  // Dispatch from the instruction buffer
  logic              in_valid;
  logic [OPC_W-1:0]  in_opcode;
  logic [TAG_W-1:0]  in_rt;
  logic              in_a_valid;
  logic [DATA_W-1:0] in_a_value;
  logic [TAG_W-1:0]  in_a_owner;
  logic              in_b_valid;
  logic [DATA_W-1:0] in_b_value;
  logic [TAG_W-1:0]  in_b_owner;

  // ROB result broadcast, one lane per ROB slot
  logic [ROB_SIZE-1:0]             rob_output_valid;
  logic [ROB_SIZE-1:0][DATA_W-1:0] rob_output_values;

  // Steering feedback to the instruction buffer
  logic              full;

  // Issue handshake towards the FXU
  logic              issue_valid;
  logic              issue_ready;
  logic [OPC_W-1:0]  issue_opcode;
  logic [TAG_W-1:0]  issue_rt;
  logic [DATA_W-1:0] issue_a;
  logic [DATA_W-1:0] issue_b;

  modport slave (
    input  in_valid, in_opcode, in_rt,
    input  in_a_valid, in_a_value, in_a_owner,
    input  in_b_valid, in_b_value, in_b_owner,
    input  rob_output_valid, rob_output_values,
    input  issue_ready,
    output full,
    output issue_valid, issue_opcode, issue_rt, issue_a, issue_b
  );

  modport master (
    output in_valid, in_opcode, in_rt,
    output in_a_valid, in_a_value, in_a_owner,
    output in_b_valid, in_b_value, in_b_owner,
    output rob_output_valid, rob_output_values,
    output issue_ready,
    input  full,
    input  issue_valid, issue_opcode, issue_rt, issue_a, issue_b
  );

endinterface

// File: rtl/fxu_reservation_station_operand.sv
// One source operand of one reservation-station entry. Captures the operand
// at dispatch (taking the ROB broadcast directly when the value is being
// produced that same cycle) and afterwards snoops the broadcast for its tag.
module rs_operand_slot
  import ooo_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            load,
  input  logic                            in_valid,
  input  logic [DATA_W-1:0]               in_value,
  input  logic [TAG_W-1:0]                in_owner,
  input  logic [ROB_SIZE-1:0]             rob_output_valid,
  input  logic [ROB_SIZE-1:0][DATA_W-1:0] rob_output_values,
  output logic                            rdy,
  output logic [DATA_W-1:0]               value
);

  operand_t op_reg;

  // Dispatch capture with same-cycle bypass, otherwise wakeup on owner tag.
  // The owner is only looked at while rdy=0, so stale tags are harmless.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      op_reg <= '0;
    end else if (load) begin
      op_reg.owner <= in_owner;
      if (in_valid) begin
        op_reg.rdy   <= 1'b1;
        op_reg.value <= in_value;
      end else if (rob_output_valid[in_owner]) begin
        op_reg.rdy   <= 1'b1;
        op_reg.value <= rob_output_values[in_owner];
      end else begin
        op_reg.rdy   <= 1'b0;
        op_reg.value <= '0;
      end
    end else if (!op_reg.rdy && rob_output_valid[op_reg.owner]) begin
      op_reg.rdy   <= 1'b1;
      op_reg.value <= rob_output_values[op_reg.owner];
    end
  end

  assign rdy   = op_reg.rdy;
  assign value = op_reg.value;

endmodule

// File: rtl/fxu_reservation_station.sv
// Reservation station for one fixed-point unit: DEPTH entries waiting on
// ROB results, lowest-index-first selection into a single output register
// that drives a valid/ready issue port.
module fxu_reservation_station
  import ooo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  fxu_reservation_station_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  valid_reg;
  logic [OPC_W-1:0]  opcode_reg [DEPTH];
  logic [TAG_W-1:0]  rt_reg     [DEPTH];
  logic [DEPTH-1:0]  a_rdy;
  logic [DEPTH-1:0]  b_rdy;
  logic [DATA_W-1:0] a_value    [DEPTH];
  logic [DATA_W-1:0] b_value    [DEPTH];
  logic [DEPTH-1:0]  ready;

  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  sel_idx;
  logic              has_ready;
  logic              full_int;
  logic              dispatch;
  logic              load_out;

  logic              issue_valid_reg;
  logic [OPC_W-1:0]  issue_opcode_reg;
  logic [TAG_W-1:0]  issue_rt_reg;
  logic [DATA_W-1:0] issue_a_reg;
  logic [DATA_W-1:0] issue_b_reg;

  // full comes from registered valid bits only; a slot freed by this
  // cycle's output load is offered to dispatch one cycle later.
  assign full_int  = &valid_reg;
  assign ready     = valid_reg & a_rdy & b_rdy;
  assign has_ready = |ready;
  assign dispatch  = bus.in_valid & ~full_int & ~flush;
  assign load_out  = (~issue_valid_reg | bus.issue_ready) & has_ready;

  // Lowest free slot for dispatch and lowest ready slot for issue.
  always_comb begin
    free_idx = IDX_W'(lowest_index(8'(~valid_reg)));
    sel_idx  = IDX_W'(lowest_index(8'(ready)));
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic dispatch_here;
      logic load_here;

      assign dispatch_here = dispatch && (free_idx == IDX_W'(gi));
      assign load_here     = load_out && (sel_idx == IDX_W'(gi));

      rs_operand_slot u_a (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .load              (dispatch_here),
        .in_valid          (bus.in_a_valid),
        .in_value          (bus.in_a_value),
        .in_owner          (bus.in_a_owner),
        .rob_output_valid  (bus.rob_output_valid),
        .rob_output_values (bus.rob_output_values),
        .rdy               (a_rdy[gi]),
        .value             (a_value[gi])
      );

      rs_operand_slot u_b (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .load              (dispatch_here),
        .in_valid          (bus.in_b_valid),
        .in_value          (bus.in_b_value),
        .in_owner          (bus.in_b_owner),
        .rob_output_valid  (bus.rob_output_valid),
        .rob_output_values (bus.rob_output_values),
        .rdy               (b_rdy[gi]),
        .value             (b_value[gi])
      );

      // Entry occupancy: set on dispatch, cleared when moved to the output.
      // Dispatch only targets free slots and load only valid ones, so the
      // two never collide on the same entry.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_reg[gi]  <= 1'b0;
          opcode_reg[gi] <= '0;
          rt_reg[gi]     <= '0;
        end else if (flush) begin
          valid_reg[gi]  <= 1'b0;
        end else if (dispatch_here) begin
          valid_reg[gi]  <= 1'b1;
          opcode_reg[gi] <= bus.in_opcode;
          rt_reg[gi]     <= bus.in_rt;
        end else if (load_here) begin
          valid_reg[gi]  <= 1'b0;
        end
      end
    end
  endgenerate

  // Output register: refill whenever it is empty or being consumed, hold
  // while stalled, and drop valid once consumed with nothing to replace it.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      issue_valid_reg  <= 1'b0;
      issue_opcode_reg <= '0;
      issue_rt_reg     <= '0;
      issue_a_reg      <= '0;
      issue_b_reg      <= '0;
    end else if (load_out) begin
      issue_valid_reg  <= 1'b1;
      issue_opcode_reg <= opcode_reg[sel_idx];
      issue_rt_reg     <= rt_reg[sel_idx];
      issue_a_reg      <= a_value[sel_idx];
      issue_b_reg      <= b_value[sel_idx];
    end else if (bus.issue_ready) begin
      issue_valid_reg  <= 1'b0;
    end
  end

  assign bus.full         = full_int;
  assign bus.issue_valid  = issue_valid_reg;
  assign bus.issue_opcode = issue_opcode_reg;
  assign bus.issue_rt     = issue_rt_reg;
  assign bus.issue_a      = issue_a_reg;
  assign bus.issue_b      = issue_b_reg;

endmodule

// File: tb/tb_fxu_reservation_station.sv
// Directed bench for fxu_reservation_station: stimulus pushes expected
// issues into a queue, a negedge monitor pops one per FXU transfer.
module tb_fxu_reservation_station;
  import ooo_pkg::*;

  typedef struct packed {
    logic [OPC_W-1:0]  opc;
    logic [TAG_W-1:0]  rt;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush;
  int   tests;
  int   fails;
  exp_t exp_q[$];

  fxu_reservation_station_if bus();

  fxu_reservation_station #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Drive one dispatch for a single cycle, then drop in_valid.
  task automatic dispatch(input logic [3:0] opc, input logic [3:0] rt,
                          input logic av, input logic [15:0] aval, input logic [3:0] aown,
                          input logic bv, input logic [15:0] bval, input logic [3:0] bown);
    bus.in_valid   = 1'b1;
    bus.in_opcode  = opc;
    bus.in_rt      = rt;
    bus.in_a_valid = av;
    bus.in_a_value = aval;
    bus.in_a_owner = aown;
    bus.in_b_valid = bv;
    bus.in_b_value = bval;
    bus.in_b_owner = bown;
    tick();
    bus.in_valid   = 1'b0;
  endtask

  // Scoreboard monitor: one line per completed issue transfer.
  always @(negedge clk) begin
    if (rst_n && bus.issue_valid && bus.issue_ready) begin
      exp_t got;
      exp_t want;
      got = '{opc: bus.issue_opcode, rt: bus.issue_rt, a: bus.issue_a, b: bus.issue_b};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL issue_unexpected: got opc=%h rt=%h a=%h b=%h, required no issue",
                 got.opc, got.rt, got.a, got.b);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          fails++;
          $display("FAIL issue_data: got opc=%h rt=%h a=%h b=%h, required opc=%h rt=%h a=%h b=%h",
                   got.opc, got.rt, got.a, got.b, want.opc, want.rt, want.a, want.b);
        end else begin
          $display("[TB] issue opc=%h rt=%h a=%h b=%h", got.opc, got.rt, got.a, got.b);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_opcode = '0;
    bus.in_rt = '0;
    bus.in_a_valid = 1'b0;
    bus.in_a_value = '0;
    bus.in_a_owner = '0;
    bus.in_b_valid = 1'b0;
    bus.in_b_value = '0;
    bus.in_b_owner = '0;
    bus.rob_output_valid = '0;
    bus.rob_output_values = '0;
    bus.issue_ready = 1'b1;

    // Reset with a dispatch attempt that must be discarded
    bus.in_valid = 1'b1;
    bus.in_a_valid = 1'b1;
    bus.in_a_value = 16'h1234;
    bus.in_b_valid = 1'b1;
    bus.in_b_value = 16'h5678;
    tick();
    tick();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("reset_full", 32'(bus.full), 32'd0);
    check("reset_issue_valid", 32'(bus.issue_valid), 32'd0);
    check("reset_issue_a", 32'(bus.issue_a), 32'd0);
    tick();
    @(negedge clk);
    check("reset_no_dispatch", 32'(bus.issue_valid), 32'd0);

    // Both operands ready: two-cycle dispatch-to-issue latency
    dispatch(4'd3, 4'd5, 1'b1, 16'h0011, 4'd0, 1'b1, 16'h0022, 4'd0);
    exp_q.push_back('{opc: 4'd3, rt: 4'd5, a: 16'h0011, b: 16'h0022});
    @(negedge clk);
    check("lat_not_yet", 32'(bus.issue_valid), 32'd0);
    tick();
    @(negedge clk);
    check("lat_valid", 32'(bus.issue_valid), 32'd1);
    check("lat_rt", 32'(bus.issue_rt), 32'd5);
    tick();
    @(negedge clk);
    check("lat_drop", 32'(bus.issue_valid), 32'd0);

    // Wakeup: A waits on tag 7
    dispatch(4'd1, 4'd2, 1'b0, 16'h0000, 4'd7, 1'b1, 16'h0005, 4'd0);
    exp_q.push_back('{opc: 4'd1, rt: 4'd2, a: 16'hBEEF, b: 16'h0005});
    tick();
    @(negedge clk);
    check("wake_waiting", 32'(bus.issue_valid), 32'd0);
    bus.rob_output_valid[7] = 1'b1;
    bus.rob_output_values[7] = 16'hBEEF;
    tick();
    bus.rob_output_valid[7] = 1'b0;
    @(negedge clk);
    check("wake_not_yet", 32'(bus.issue_valid), 32'd0);
    tick();
    @(negedge clk);
    check("wake_valid", 32'(bus.issue_valid), 32'd1);
    check("wake_a", 32'(bus.issue_a), 32'h0000BEEF);
    tick();

    // Bypass: tag 7 broadcast during the dispatch cycle itself
    bus.rob_output_valid[7] = 1'b1;
    dispatch(4'd4, 4'd6, 1'b0, 16'hDEAD, 4'd7, 1'b1, 16'h0007, 4'd0);
    bus.rob_output_valid[7] = 1'b0;
    bus.rob_output_values[7] = 16'h0000;
    exp_q.push_back('{opc: 4'd4, rt: 4'd6, a: 16'hBEEF, b: 16'h0007});
    tick();
    @(negedge clk);
    check("bypass_valid", 32'(bus.issue_valid), 32'd1);
    check("bypass_a", 32'(bus.issue_a), 32'h0000BEEF);
    tick();

    // Fill all four entries waiting on tag 9; a fifth dispatch is ignored
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fill_not_full", 32'(bus.full), 32'd0);
      tick();
      dispatch(4'(8 + i), 4'(i), 1'b0, 16'h0000, 4'd9, 1'b1, 16'(16'h0100 + i), 4'd0);
    end
    @(negedge clk);
    check("fill_full", 32'(bus.full), 32'd1);
    tick();
    dispatch(4'hF, 4'hF, 1'b1, 16'hFFFF, 4'd0, 1'b1, 16'hFFFF, 4'd0);
    @(negedge clk);
    check("fifth_full", 32'(bus.full), 32'd1);
    check("fifth_no_issue", 32'(bus.issue_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{opc: 4'(8 + i), rt: 4'(i), a: 16'h0909, b: 16'(16'h0100 + i)});
    end
    tick();
    bus.rob_output_valid[9] = 1'b1;
    bus.rob_output_values[9] = 16'h0909;
    tick();
    bus.rob_output_valid[9] = 1'b0;
    @(negedge clk);
    check("bcast_still_full", 32'(bus.full), 32'd1);
    tick();
    @(negedge clk);
    check("first_load_valid", 32'(bus.issue_valid), 32'd1);
    check("first_load_unfull", 32'(bus.full), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    check("drain_done", 32'(bus.issue_valid), 32'd0);

    // Stall: issue data must hold while issue_ready=0
    bus.issue_ready = 1'b0;
    dispatch(4'd2, 4'd10, 1'b1, 16'h00A1, 4'd0, 1'b1, 16'h00A2, 4'd0);
    dispatch(4'd3, 4'd11, 1'b1, 16'h00B1, 4'd0, 1'b1, 16'h00B2, 4'd0);
    exp_q.push_back('{opc: 4'd2, rt: 4'd10, a: 16'h00A1, b: 16'h00A2});
    exp_q.push_back('{opc: 4'd3, rt: 4'd11, a: 16'h00B1, b: 16'h00B2});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.issue_valid), 32'd1);
      check("hold_rt", 32'(bus.issue_rt), 32'd10);
      check("hold_a", 32'(bus.issue_a), 32'h000000A1);
      check("hold_b", 32'(bus.issue_b), 32'h000000A2);
      tick();
    end
    bus.issue_ready = 1'b1;
    tick();
    @(negedge clk);
    check("b2b_second_rt", 32'(bus.issue_rt), 32'd11);
    tick();
    @(negedge clk);
    check("b2b_drop", 32'(bus.issue_valid), 32'd0);

    // Flush with two resident entries and one in the output register
    bus.issue_ready = 1'b0;
    dispatch(4'd5, 4'd12, 1'b1, 16'h0C01, 4'd0, 1'b1, 16'h0C02, 4'd0);
    dispatch(4'd6, 4'd13, 1'b1, 16'h0D01, 4'd0, 1'b1, 16'h0D02, 4'd0);
    dispatch(4'd7, 4'd14, 1'b1, 16'h0E01, 4'd0, 1'b1, 16'h0E02, 4'd0);
    @(negedge clk);
    check("preflush_valid", 32'(bus.issue_valid), 32'd1);
    tick();
    flush = 1'b1;
    dispatch(4'd9, 4'd15, 1'b1, 16'h0F01, 4'd0, 1'b1, 16'h0F02, 4'd0);
    flush = 1'b0;
    @(negedge clk);
    check("flush_issue_valid", 32'(bus.issue_valid), 32'd0);
    check("flush_full", 32'(bus.full), 32'd0);
    check("flush_issue_a", 32'(bus.issue_a), 32'd0);
    bus.issue_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("flush_empty", 32'(bus.issue_valid), 32'd0);
    end

    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
